// File: rtl/pic_bus_initiator_if.sv
// PIC read/write-logic port: chip select, strobes, address bit and data bus.
interface pic_bus_initiator_if;
  logic       CS;
  logic       write;
  logic       Read;
  logic       A0;
  logic [7:0] dataBuffer;
  logic       data_oe;
  logic [7:0] dataBuffer_in;

  modport master (
    output CS, write, Read, A0, dataBuffer, data_oe,
    input  dataBuffer_in
  );

  modport slave (
    input  CS, write, Read, A0, dataBuffer, data_oe,
    output dataBuffer_in
  );
endinterface

// File: rtl/pic_bus_initiator.sv
// CPU-side bus initiator for the 8259A: sequences ICW init, single OCW writes
// and register reads into timed CS/write/Read cycles.
module pic_bus_initiator #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_start,
  input  logic [7:0]  icw1,
  input  logic [7:0]  icw2,
  input  logic [7:0]  icw3,
  input  logic [7:0]  icw4,
  input  logic        ocw_req,
  input  logic [1:0]  ocw_sel,
  input  logic [7:0]  ocw_data,
  input  logic        rd_req,
  input  logic        rd_a0,
  pic_bus_initiator_if.master bus,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        init_done,
  output logic        rd_valid,
  output logic [7:0]  rd_data
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;
  typedef enum logic [1:0] {K_INIT, K_OCW, K_READ} kind_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

  state_t     state_q, state_n;
  kind_t      kind_q;
  logic [7:0] cnt_q, cnt_n;
  logic [1:0] idx_q, idx_n, idx_next;
  logic       has_next;
  logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q;
  logic       w_a0_q;
  logic [7:0] w_data_q;
  logic       cur_a0;
  logic [7:0] cur_data;
  logic       is_rd;

  logic       acc_init, acc_ocw, acc_rd, reject, last_gap, capture;
  logic       cs_d, wr_d, rd_d, a0_d, oe_d, busy_d, done_d, rdv_d;
  logic [7:0] data_d;
  logic       cs_q, wr_q, rd_q, a0_q, oe_q, busy_q, done_q, err_q, init_done_q, rdv_q;
  logic [7:0] data_q, rd_data_q;

  assign is_rd = (kind_q == K_READ);

  // Current word's A0/data and which init word (if any) follows it
  always_comb begin
    cur_a0   = w_a0_q;
    cur_data = w_data_q;
    has_next = 1'b0;
    idx_next = idx_q;
    if (kind_q == K_INIT) begin
      case (idx_q)
        2'd0:    begin cur_a0 = 1'b0; cur_data = icw1_q; end
        2'd1:    begin cur_a0 = 1'b1; cur_data = icw2_q; end
        2'd2:    begin cur_a0 = 1'b1; cur_data = icw3_q; end
        default: begin cur_a0 = 1'b1; cur_data = icw4_q; end
      endcase
      // ICW3 only in cascade mode (SNGL=0), ICW4 only when IC4=1
      case (idx_q)
        2'd0: begin has_next = 1'b1; idx_next = 2'd1; end
        2'd1: begin
          if (!icw1_q[1])     begin has_next = 1'b1; idx_next = 2'd2; end
          else if (icw1_q[0]) begin has_next = 1'b1; idx_next = 2'd3; end
        end
        2'd2: if (icw1_q[0]) begin has_next = 1'b1; idx_next = 2'd3; end
        default: ;
      endcase
    end
  end

  // Next state and next registered bus outputs; outputs lag the state by one
  // cycle so the bus changes one cycle after a request is accepted
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    acc_init = 1'b0;
    acc_ocw  = 1'b0;
    acc_rd   = 1'b0;
    reject   = 1'b0;
    last_gap = 1'b0;
    capture  = 1'b0;
    cs_d     = 1'b1;
    wr_d     = 1'b1;
    rd_d     = 1'b1;
    a0_d     = 1'b0;
    data_d   = '0;
    oe_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    rdv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_start) begin
          acc_init = 1'b1;
          state_n  = SETUP;
          cnt_n    = '0;
          idx_n    = 2'd0;
        end else if (ocw_req) begin
          if (!init_done_q || ocw_sel == 2'd0) begin
            reject = 1'b1;
          end else begin
            acc_ocw = 1'b1;
            state_n = SETUP;
            cnt_n   = '0;
            idx_n   = 2'd0;
          end
        end else if (rd_req) begin
          acc_rd  = 1'b1;
          state_n = SETUP;
          cnt_n   = '0;
          idx_n   = 2'd0;
        end
      end
      SETUP: begin
        cs_d   = 1'b0;
        a0_d   = cur_a0;
        data_d = cur_data;
        oe_d   = !is_rd;
        busy_d = 1'b1;
        if (cnt_q == SETUP_LAST) begin
          state_n = STROBE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      STROBE: begin
        cs_d   = 1'b0;
        wr_d   = is_rd;
        rd_d   = !is_rd;
        a0_d   = cur_a0;
        data_d = cur_data;
        oe_d   = !is_rd;
        busy_d = 1'b1;
        if (cnt_q == PULSE_LAST) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        cs_d   = 1'b0;
        a0_d   = cur_a0;
        data_d = cur_data;
        oe_d   = !is_rd;
        busy_d = 1'b1;
        // first HOLD state cycle is when the last visible strobe cycle ends
        capture = is_rd && (cnt_q == 8'd0);
        if (cnt_q == HOLD_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      GAP: begin
        a0_d   = cur_a0;
        data_d = cur_data;
        busy_d = 1'b1;
        if (has_next) begin
          idx_n   = idx_next;
          state_n = SETUP;
          cnt_n   = '0;
        end else begin
          done_d   = 1'b1;
          rdv_d    = is_rd;
          last_gap = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, latched request words and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      kind_q      <= K_INIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      icw1_q      <= '0;
      icw2_q      <= '0;
      icw3_q      <= '0;
      icw4_q      <= '0;
      w_a0_q      <= 1'b0;
      w_data_q    <= '0;
      cs_q        <= 1'b1;
      wr_q        <= 1'b1;
      rd_q        <= 1'b1;
      a0_q        <= 1'b0;
      data_q      <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      rdv_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      a0_q    <= a0_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= reject;
      rdv_q   <= rdv_d;
      if (acc_init) begin
        kind_q      <= K_INIT;
        icw1_q      <= icw1 | 8'h10;
        icw2_q      <= icw2;
        icw3_q      <= icw3;
        icw4_q      <= icw4;
        init_done_q <= 1'b0;
      end else if (last_gap && kind_q == K_INIT) begin
        init_done_q <= 1'b1;
      end
      if (acc_ocw) begin
        kind_q <= K_OCW;
        case (ocw_sel)
          2'd1: begin
            w_a0_q   <= 1'b1;
            w_data_q <= ocw_data;
          end
          2'd2: begin
            w_a0_q   <= 1'b0;
            w_data_q <= {ocw_data[7:5], 2'b00, ocw_data[2:0]};
          end
          default: begin
            w_a0_q   <= 1'b0;
            w_data_q <= {ocw_data[7:5], 2'b01, ocw_data[2:0]};
          end
        endcase
      end
      if (acc_rd) begin
        kind_q   <= K_READ;
        w_a0_q   <= rd_a0;
        w_data_q <= '0;
      end
      if (capture) rd_data_q <= bus.dataBuffer_in;
    end
  end

  assign bus.CS         = cs_q;
  assign bus.write      = wr_q;
  assign bus.Read       = rd_q;
  assign bus.A0         = a0_q;
  assign bus.dataBuffer = data_q;
  assign bus.data_oe    = oe_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign init_done      = init_done_q;
  assign rd_valid       = rdv_q;
  assign rd_data        = rd_data_q;

endmodule

// File: tb/tb_pic_bus_initiator.sv
// Directed bench for pic_bus_initiator: vector table plus hand sequences.
module tb_pic_bus_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_start, ocw_req, rd_req, rd_a0;
  logic [7:0] icw1, icw2, icw3, icw4, ocw_data;
  logic [1:0] ocw_sel;
  logic       busy, done, err, init_done, rd_valid;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;
  logic       exp_init;
  logic [7:0] exp_rd;

  pic_bus_initiator_if bus();

  pic_bus_initiator #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .ocw_req(ocw_req), .ocw_sel(ocw_sel), .ocw_data(ocw_data),
    .rd_req(rd_req), .rd_a0(rd_a0), .bus(bus),
    .busy(busy), .done(done), .err(err), .init_done(init_done),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // kind: 0 init, 1 ocw, 2 read; n=0 means the request must be rejected
  typedef struct {
    int         kind;
    bit         both;
    logic [7:0] b1, b2, b3, b4;
    logic [1:0] sel;
    logic       rda0;
    logic [7:0] din;
    int         n;
    logic [3:0] a0s;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(int kind, bit both, logic [7:0] b1, b2, b3, b4,
                              logic [1:0] sel, logic rda0, logic [7:0] din, int n,
                              logic [3:0] a0s, logic [7:0] d0, d1, d2, d3);
    vec_t v;
    v.kind = kind; v.both = both;
    v.b1 = b1; v.b2 = b2; v.b3 = b3; v.b4 = b4;
    v.sel = sel; v.rda0 = rda0; v.din = din; v.n = n;
    v.a0s = a0s; v.ed = {d3, d2, d1, d0};
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    int  total;
    bit  isr;
    int  w, p;
    logic ecs, ewr, erd, eoe, ebusy, edone, erdv;
    case (v.kind)
      0: begin
        init_start = 1'b1;
        icw1 = v.b1; icw2 = v.b2; icw3 = v.b3; icw4 = v.b4;
        if (v.both) begin ocw_req = 1'b1; ocw_sel = 2'd1; ocw_data = 8'h55; end
      end
      1: begin ocw_req = 1'b1; ocw_sel = v.sel; ocw_data = v.b1; end
      default: begin rd_req = 1'b1; rd_a0 = v.rda0; bus.dataBuffer_in = v.din; end
    endcase
    tick;
    init_start = 1'b0; ocw_req = 1'b0; rd_req = 1'b0;
    if (v.n == 0) begin
      chk($sformatf("v%0d err_pulse", id), 32'(err), 32'd1);
      chk($sformatf("v%0d rej_cs_busy", id), 32'({bus.CS, busy}), 32'b10);
      tick;
      chk($sformatf("v%0d err_clear", id), 32'(err), 32'd0);
      chk($sformatf("v%0d rej_idle", id), 32'({bus.CS, busy}), 32'b10);
    end else begin
      total = v.n * 5;
      isr   = (v.kind == 2);
      for (int k = 1; k <= total + 1; k++) begin
        tick;
        w = (k - 1) / 5;
        p = (k - 1) % 5;
        ecs   = !(k <= total && p <= 3);
        ewr   = !(k <= total && (p == 1 || p == 2) && !isr);
        erd   = !(k <= total && (p == 1 || p == 2) && isr);
        eoe   = (k <= total && p <= 3 && !isr);
        ebusy = (k <= total);
        edone = (k == total);
        erdv  = (k == total) && isr;
        chk($sformatf("v%0d ctl@E+%0d", id, k),
            32'({bus.CS, bus.write, bus.Read, bus.data_oe, busy, done, rd_valid, err}),
            32'({ecs, ewr, erd, eoe, ebusy, edone, erdv, 1'b0}));
        if (!ecs) begin
          chk($sformatf("v%0d A0@E+%0d", id, k), 32'(bus.A0), 32'(v.a0s[w]));
          if (!isr)
            chk($sformatf("v%0d data@E+%0d", id, k), 32'(bus.dataBuffer), 32'(v.ed[w*8 +: 8]));
        end
      end
      if (v.both) begin
        tick;
        chk($sformatf("v%0d ocw_dropped", id), 32'({bus.CS, busy, err}), 32'b100);
      end
      if (v.kind == 0) exp_init = 1'b1;
      if (isr) exp_rd = v.din;
    end
    chk($sformatf("v%0d init_done", id), 32'(init_done), 32'(exp_init));
    chk($sformatf("v%0d rd_data", id), 32'(rd_data), 32'(exp_rd));
  endtask

  initial begin
    reset = 1'b1;
    init_start = 1'b0; ocw_req = 1'b0; rd_req = 1'b0; rd_a0 = 1'b0;
    icw1 = '0; icw2 = '0; icw3 = '0; icw4 = '0;
    ocw_sel = '0; ocw_data = '0;
    bus.dataBuffer_in = '0;
    exp_init = 1'b0;
    exp_rd   = '0;

    vecs[0] = mk(2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 8'hA5, 1, 4'b0001, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[1] = mk(0, 1, 8'h11, 8'h20, 8'h04, 8'h01, 2'd0, 1'b0, 8'h00, 4, 4'b1110, 8'h11, 8'h20, 8'h04, 8'h01);
    vecs[2] = mk(0, 0, 8'h13, 8'h40, 8'h99, 8'h03, 2'd0, 1'b0, 8'h00, 3, 4'b0110, 8'h13, 8'h40, 8'h03, 8'h00);
    vecs[3] = mk(0, 0, 8'h02, 8'h28, 8'h77, 8'h66, 2'd0, 1'b0, 8'h00, 2, 4'b0010, 8'h12, 8'h28, 8'h00, 8'h00);
    vecs[4] = mk(1, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 2'd2, 1'b0, 8'h00, 1, 4'b0000, 8'hE7, 8'h00, 8'h00, 8'h00);
    vecs[5] = mk(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd3, 1'b0, 8'h00, 1, 4'b0000, 8'h08, 8'h00, 8'h00, 8'h00);
    vecs[6] = mk(1, 0, 8'h55, 8'h00, 8'h00, 8'h00, 2'd1, 1'b0, 8'h00, 1, 4'b0001, 8'h55, 8'h00, 8'h00, 8'h00);
    vecs[7] = mk(2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 8'h3C, 1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[8] = mk(1, 0, 8'h12, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

    // reset values
    tick;
    tick;
    chk("reset ctl", 32'({bus.CS, bus.write, bus.Read, bus.data_oe, busy, done, rd_valid, err}),
        32'b1110_0000);
    chk("reset A0/data", 32'({bus.A0, bus.dataBuffer}), 32'h0);
    chk("reset init_done/rd_data", 32'({init_done, rd_data}), 32'h0);
    reset = 1'b0;
    tick;

    // OCW before initialization is rejected without bus activity
    ocw_req = 1'b1; ocw_sel = 2'd1; ocw_data = 8'h55;
    tick;
    ocw_req = 1'b0;
    chk("early_ocw err", 32'(err), 32'd1);
    chk("early_ocw cs_busy", 32'({bus.CS, busy}), 32'b10);
    tick;
    chk("early_ocw err_clear", 32'(err), 32'd0);
    chk("early_ocw idle", 32'({bus.CS, busy}), 32'b10);

    // reset in the middle of an init strobe
    init_start = 1'b1; icw1 = 8'h11; icw2 = 8'h20; icw3 = 8'h04; icw4 = 8'h01;
    tick;
    init_start = 1'b0;
    tick;
    chk("midrst setup cs", 32'({bus.CS, bus.write}), 32'b01);
    tick;
    chk("midrst strobe", 32'({bus.CS, bus.write}), 32'b00);
    reset = 1'b1;
    tick;
    chk("midrst after", 32'({bus.CS, bus.write, bus.Read, busy, init_done, bus.data_oe}), 32'b111000);
    reset = 1'b0;
    tick;
    chk("midrst no_resume", 32'({bus.CS, busy}), 32'b10);

    for (int i = 0; i < 9; i++) apply(vecs[i], i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_bus_initiator.md
# pic_bus_initiator

CPU-side bus initiator for the 8259A PIC: turns host-level requests (initialization sequence, single OCW write, register read) into correctly sequenced, active-low CS/write/Read bus cycles with A0 and data. It drives the PIC's read/write logic port and is the write-side counterpart of the ICW/OCW decoder. It also runs the ICW1→ICW2→(ICW3)→(ICW4) sequence autonomously.

## Interface
- SETUP_CYC, 1: cycles CS low, data/A0 valid, before the strobe (≥1)
- PULSE_CYC, 2: cycles the write/Read strobe is low (≥1)
- HOLD_CYC, 1: cycles CS low and data held after the strobe (≥1)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- init_start  in  1  pulse: start the initialization sequence
- icw1, icw2, icw3, icw4  in  8 each  initialization words, sampled at acceptance
- ocw_req  in  1  pulse: write one OCW
- ocw_sel  in  2  1=OCW1, 2=OCW2, 3=OCW3 (0 illegal)
- ocw_data  in  8  OCW payload, sampled at acceptance
- rd_req  in  1  pulse: one read cycle
- rd_a0  in  1  A0 for the read
- dataBuffer_in  in  8  PIC data bus during reads
- CS  out  1  chip select, active low
- write  out  1  write strobe, active low
- Read  out  1  read strobe, active low
- A0  out  1  address bit
- dataBuffer  out  8  data driven to PIC
- data_oe  out  1  1 while dataBuffer is driven (write cycles only)
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejection pulse
- init_done  out  1  initialization completed since last reset/init_start
- rd_valid  out  1  one-cycle pulse, rd_data updated
- rd_data  out  8  last captured read value

## Operation
- States: IDLE, SETUP, STROBE, HOLD, GAP. Per word: SETUP (SETUP_CYC) → STROBE (PULSE_CYC) → HOLD (HOLD_CYC) → GAP (1 cycle, CS=1, strobes high, data_oe=0).
- Requests sampled only in IDLE; ignored (not queued) while busy. Simultaneous: init_start > ocw_req > rd_req.
- Init: words ICW1 (A0=0), ICW2 (A0=1), ICW3 (A0=1) only if icw1[1]=0, ICW4 (A0=1) only if icw1[0]=1. ICW1 bit4 forced to 1 on the bus. init_done cleared at acceptance, set in the final GAP cycle.
- OCW: OCW1 A0=1 data unchanged; OCW2 A0=0, bits[4:3] forced 00; OCW3 A0=0, bits[4:3] forced 01.
- OCW rejected (err=1 one cycle, no bus activity, busy stays 0) when init_done=0 or ocw_sel=0.
- Read: A0=rd_a0, Read strobe instead of write, data_oe=0 throughout; dataBuffer_in captured on the edge ending the last STROBE cycle; rd_valid pulses with done. Reads allowed regardless of init_done.
- write and Read never both low; strobes only low while CS low.

## Timing
- Reset values: CS=1, write=1, Read=1, A0=0, dataBuffer=0, data_oe=0, busy=0, done=0, err=0, init_done=0, rd_valid=0, rd_data=0, state IDLE.
- Request accepted on edge E: CS low, A0/data valid, busy=1 from cycle E+1. Word length W = SETUP_CYC+PULSE_CYC+HOLD_CYC+1 (defaults: 5).
- Transaction of N words: done (and rd_valid for reads) high in cycle E+N·W; busy falls at edge E+N·W+1; new request acceptable in that cycle. Defaults: 4-word init done at E+20, single OCW/read at E+5.
- A0 and dataBuffer stable from first SETUP through last HOLD cycle of each word.
- Reset mid-transaction: all outputs return to reset values on the next edge; no partial words resumed.

## Test plan
- Reset mid-STROBE of an init → next cycle CS=write=1, busy=0, init_done=0.
- init_start with icw1=0x11, icw2=0x20, icw3=0x04, icw4=0x01 → 4 writes, A0 0,1,1,1, data 0x11,0x20,0x04,0x01, write low 2 cycles each, done at E+20, init_done=1.
- icw1=0x13 → 3 writes (ICW3 skipped), done at E+15; icw1=0x02 → 2 writes, bus ICW1=0x12, done at E+10.
- After init: OCW2 data 0xFF → A0=0, bus 0xE7; OCW3 data 0x00 → bus 0x08, A0=0; OCW1 0x55 → A0=1, bus 0x55; each done at E+5.
- ocw_req before init → err=1, CS stays 1; init_start and ocw_req same cycle → init runs, OCW dropped.
- rd_req rd_a0=1, dataBuffer_in=0xA5 → Read low 2 cycles, data_oe=0, rd_valid and done at E+5, rd_data=0xA5 held until next read.
